// File: rtl/rvvi_serial_pkg.sv
// rvvi_serial_pkg: configuration, derived widths and FIFO entry type for the retire serializer
// Optional: RVVI_SERIAL_TIMESTAMP_EN adds a 32-bit push-cycle stamp to every entry.
package rvvi_serial_pkg;
    localparam int NHART = 2;
    localparam int NRET  = 2;
    localparam int ILEN  = 32;
    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int LANES = NHART * NRET;
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = PTRW + 1;
    localparam int HW    = NHART > 1 ? $clog2(NHART) : 1;
    localparam int SW    = NRET > 1 ? $clog2(NRET) : 1;
    typedef struct packed {
        logic [HW-1:0]   hart;
        logic [SW-1:0]   slot;
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
`ifdef RVVI_SERIAL_TIMESTAMP_EN
        logic [31:0]     cycle;
`endif
    } retire_entry_t;
endpackage

// File: rtl/rvvi_retire_serializer_if.sv
// rvvi_retire_serializer_if: RVVI retire lanes in, serialized retire stream and status out
// master: trace/sampler side (drives in_*, out_ready); slave: serializer (drives out_*, count, overflow, drop_cnt).
// Optional: RVVI_SERIAL_TIMESTAMP_EN adds out_cycle.
interface rvvi_retire_serializer_if;
    import rvvi_serial_pkg::*;
    logic [LANES-1:0]      in_valid;
    logic [LANES*ILEN-1:0] in_insn;
    logic [LANES*XLEN-1:0] in_pc;
    logic [LANES-1:0]      in_trap;
    logic                  out_valid;
    logic                  out_ready;
    logic [HW-1:0]         out_hart;
    logic [SW-1:0]         out_slot;
    logic [ILEN-1:0]       out_insn;
    logic [XLEN-1:0]       out_pc;
    logic                  out_trap;
    logic [CNTW-1:0]       count;
    logic                  overflow;
    logic [15:0]           drop_cnt;
`ifdef RVVI_SERIAL_TIMESTAMP_EN
    logic [31:0]           out_cycle;
`endif
    modport master (
        output in_valid, in_insn, in_pc, in_trap, out_ready,
        input
`ifdef RVVI_SERIAL_TIMESTAMP_EN
        out_cycle,
`endif
        out_valid, out_hart, out_slot, out_insn, out_pc, out_trap, count, overflow, drop_cnt
    );
    modport slave (
        input in_valid, in_insn, in_pc, in_trap, out_ready,
        output
`ifdef RVVI_SERIAL_TIMESTAMP_EN
        out_cycle,
`endif
        out_valid, out_hart, out_slot, out_insn, out_pc, out_trap, count, overflow, drop_cnt
    );
endinterface

// File: rtl/rvvi_lane_compactor.sv
// rvvi_lane_compactor: prefix-sum over lane valids giving each lane's write offset and the batch size
// valid_i: per-lane valid; off_o: offset of each lane among valid lanes; n_o: popcount of valid_i.
module rvvi_lane_compactor
    import rvvi_serial_pkg::*;
(
    input  logic [LANES-1:0] valid_i,
    output logic [PTRW-1:0]  off_o [LANES],
    output logic [CNTW-1:0]  n_o
);
    logic [CNTW-1:0] acc;
    always_comb begin
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            off_o[i] = acc[PTRW-1:0];
            acc = acc + CNTW'(valid_i[i]);
        end
        n_o = acc;
    end
endmodule

// File: rtl/rvvi_retire_serializer.sv
// rvvi_retire_serializer: buffers up to LANES retirements per cycle and emits one per cycle in lane order
// clk/reset: clock and synchronous active-high reset; bus: rvvi_retire_serializer_if.slave.
// Optional: RVVI_SERIAL_TIMESTAMP_EN stamps entries with a free-running cycle count, shown on out_cycle.
module rvvi_retire_serializer
    import rvvi_serial_pkg::*;
(
    input logic clk,
    input logic reset,
    rvvi_retire_serializer_if.slave bus
);
    retire_entry_t   mem_q [DEPTH];
    retire_entry_t   mem_d [DEPTH];
    retire_entry_t   ent [LANES];
    retire_entry_t   head;
    logic [PTRW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNTW-1:0] cnt_q, cnt_d, n_in, free;
    logic [15:0]     drop_q, drop_d;
    logic            ovf_q, ovf_d, vld, pop, acc;
    logic [PTRW-1:0] off [LANES];
`ifdef RVVI_SERIAL_TIMESTAMP_EN
    logic [31:0]     cyc_q;
    always_ff @(posedge clk) cyc_q <= reset ? '0 : cyc_q + 32'd1;
    assign bus.out_cycle = head.cycle;
`endif
    rvvi_lane_compactor u_comp (.valid_i(bus.in_valid), .off_o(off), .n_o(n_in));
    assign vld  = cnt_q != '0;
    assign pop  = vld & bus.out_ready;
    // A same-cycle pop frees its slot for this cycle's batch; batches are all-or-nothing.
    assign free = CNTW'(DEPTH) - cnt_q + CNTW'(pop);
    assign acc  = n_in <= free;
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ent[i].hart = HW'(i / NRET);
            ent[i].slot = SW'(i % NRET);
            ent[i].insn = bus.in_insn[i*ILEN +: ILEN];
            ent[i].pc   = bus.in_pc[i*XLEN +: XLEN];
            ent[i].trap = bus.in_trap[i];
`ifdef RVVI_SERIAL_TIMESTAMP_EN
            ent[i].cycle = cyc_q;
`endif
        end
    end
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < LANES; i++)
            if (acc && bus.in_valid[i]) mem_d[wr_q + off[i]] = ent[i];
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    always_comb begin
        rd_d   = rd_q + PTRW'(pop);
        wr_d   = wr_q + (acc ? n_in[PTRW-1:0] : '0);
        cnt_d  = cnt_q + (acc ? n_in : '0) - CNTW'(pop);
        ovf_d  = ovf_q | ~acc;
        drop_d = (!acc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end
    // Outputs read zero while empty so nothing stale leaks out after reset.
    assign head          = vld ? mem_q[rd_q] : '0;
    assign bus.out_valid = vld;
    assign bus.out_hart  = head.hart;
    assign bus.out_slot  = head.slot;
    assign bus.out_insn  = head.insn;
    assign bus.out_pc    = head.pc;
    assign bus.out_trap  = head.trap;
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: doc/rvvi_retire_serializer.md
Name: rvvi_retire_serializer

Overview:
- Parametrised successor to the single-hart, single-retire coverage sampling front end.
- Accepts up to NHART×NRET retirements per clock from the RVVI trace and buffers them in a circular FIFO.
- Emits exactly one retirement per cycle, in defined retirement order, to the coverage sampler through a valid/ready handshake.
- Sits between the RVVI trace interface and the coverage class sample call, so multi-hart and superscalar configurations are sampled in order.

Parameters:
- NHART, 2, number of harts traced
- NRET, 2, retire slots per hart per cycle
- ILEN, 32, instruction width
- XLEN, 64, PC width
- DEPTH, 16, FIFO entries; must be a power of two and ≥ NHART*NRET

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- in_valid  input  NHART*NRET  per-lane retire valid; lane index = h*NRET+r
- in_insn  input  NHART*NRET*ILEN  per-lane instruction
- in_pc  input  NHART*NRET*XLEN  per-lane PC
- in_trap  input  NHART*NRET  per-lane trap flag
- out_valid  output  1  head entry valid
- out_ready  input  1  sampler accepts the head entry
- out_hart  output  $clog2(NHART) or 1, whichever is larger  hart of head entry
- out_slot  output  $clog2(NRET) or 1, whichever is larger  retire slot of head entry
- out_insn  output  ILEN  instruction of head entry
- out_pc  output  XLEN  PC of head entry
- out_trap  output  1  trap flag of head entry
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky flag: a batch was dropped
- drop_cnt  output  16  number of dropped batches; saturates at 0xFFFF

Behaviour:
- Reset (synchronous, active-high): rd_ptr=0, wr_ptr=0, count=0, overflow=0, drop_cnt=0, out_valid=0. Reset mid-operation discards all buffered entries in the same edge.
- Ordering: valid lanes are compacted in ascending lane index (hart 0 slot 0 first, slot order within a hart, then hart order). The k-th valid lane is written at wr_ptr+k (mod DEPTH).
- Push size: n_in = popcount(in_valid).
- Pop: pop = out_valid & out_ready.
- Free space: free = DEPTH − count + pop. Same-cycle pop frees space for that cycle's push.
- Accept: if n_in ≤ free, all n_in entries are written.
  - wr_ptr += n_in; count += n_in − pop.
- Drop: if n_in > free, the whole batch is dropped, never a partial write.
  - overflow←1; drop_cnt increments, saturating; the pop still proceeds.
- Latency: an entry written at edge N is visible at out_valid/out_* after edge N (registered). Minimum input-to-output latency is 1 cycle.
- Outputs: out_valid = (count≠0). out_* are read from FIFO[rd_ptr] and are held stable while out_valid & !out_ready.
- Pointers: log2(DEPTH) bits, natural wrap. Full and empty are distinguished by count, not by pointer compare.
- Empty with simultaneous push: entries appear the next cycle; out_valid is never combinationally derived from in_valid.
- in_valid all zero: no state change except pop.

Optional Feature:
- Macro: RVVI_SERIAL_TIMESTAMP_EN.
- Defined: adds a 32-bit free-running cycle counter, reset to 0, wrapping at 2^32. It is stamped into every entry at push. Adds output port out_cycle [31:0], equal to the stamp of the head entry (0 at reset).
- Undefined: no counter, no out_cycle port, no extra FIFO storage.

Decomposition:
- Package rvvi_serial_pkg holds the entry struct typedef retire_entry_t {hart, slot, insn, pc, trap[, cycle]} and localparams LANES=NHART*NRET, PTRW=$clog2(DEPTH), CNTW=PTRW+1.
- One sub-module: rvvi_lane_compactor. It is combinational: a prefix-sum over in_valid produces per-lane write offsets and n_in. The FIFO and control stay in the top module.

Test Plan:
- Single lane: in_valid=0001 for 1 cycle, out_ready=1 → out_valid=1 next cycle with hart=0, slot=0; count returns to 0 the following cycle.
- Ordering: in_valid=1111 with pcs 0x100/0x104/0x200/0x204, out_ready=1 → outputs in 4 consecutive cycles as (h0,s0,0x100),(h0,s1,0x104),(h1,s0,0x200),(h1,s1,0x204).
- Sparse: in_valid=1010 → only lanes 1 and 3 are emitted, as (h0,s1) then (h1,s1); count peaks at 2.
- Overflow: out_ready=0, fill count to 14, then in_valid=1111 → batch dropped, count stays 14, overflow=1, drop_cnt=1. Same fill with out_ready=1 and n_in=3 → accepted, count=16.
- Wrap: stream 40 single-lane retires through DEPTH=16 with out_ready toggling 1/0 → all 40 emerge in order with no loss and count never exceeds 16.
- Reset mid-stream: count=9, reset=1 for 1 cycle → next cycle count=0, out_valid=0, overflow=0. With RVVI_SERIAL_TIMESTAMP_EN, out_cycle of the first post-reset push equals its cycle index from 0.
